// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the MIPS32 MEM-stage data-memory controller.
//   SZ_*         - request size encodings carried on req_size
//   dmem_state_e - controller FSM states (CLEAR sweep, IDLE service)
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } dmem_state_e;

endpackage

// File: rtl/dmem_if.sv
// dmem_if: request/response bundle between the MEM stage and dmem_ctrl.
//   master modport - pipeline side: drives req_*, observes req_ready, rsp_*, init_busy
//   slave modport  - controller side: the mirror image
// Parameter ADDR_W sets the byte-address width of req_addr.
interface dmem_if #(
    parameter int ADDR_W = 32
);
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              init_busy;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
    );

endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational little-endian lane steering for dmem_ctrl.
//   size, is_signed, addr_lo - access description (addr_lo = byte offset in word)
//   wdata                    - right-justified store data
//   rword                    - current contents of the addressed word
//   byte_en, wdata_lanes     - store lane enables and replicated store data
//   rdata_ext                - extracted and extended load result
//   misalign_err             - misaligned half/word access, only when the
//                              DMEM_MISALIGN_TRAP_EN macro is defined; otherwise
//                              the offending low address bits are ignored.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext,
    output logic        misalign_err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = 8'(rword >> {addr_lo, 3'b000});
    // A half access picks its lane pair from addr[1] alone.
    assign half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        byte_en     = 4'b0000;
        wdata_lanes = 32'h0;
        rdata_ext   = 32'h0;
        unique case (size)
            SZ_BYTE: begin
                byte_en     = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = is_signed ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
            end
            SZ_HALF: begin
                byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = is_signed ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
            end
            SZ_WORD: begin
                byte_en     = 4'b1111;
                wdata_lanes = wdata;
                rdata_ext   = rword;
            end
            default: ;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign_err = ((size == SZ_HALF) && addr_lo[0]) ||
                          ((size == SZ_WORD) && (addr_lo != 2'b00));
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: MIPS32 MEM-stage data memory with valid/ready requests and a
// registered response one cycle after acceptance.
//   clk - rising-edge clock
//   rst - asynchronous active-high reset; restarts the clear sweep
//   bus - dmem_if.slave: req_* in, req_ready / rsp_* / init_busy out
// Parameters: DEPTH words (power of two, >= 4), ADDR_W byte-address width
// (must exceed log2(DEPTH)+2). Build option DMEM_MISALIGN_TRAP_EN turns
// misaligned half/word accesses into errors (handled in dmem_lane_align).
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic  clk,
    input  logic  rst,
    dmem_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [0:0] ST_CLEAR = CLEAR;
    localparam logic [0:0] ST_IDLE  = IDLE;

    logic [0:0]       state;
    logic [IDX_W-1:0] clr_cnt;
    logic [31:0]      mem [DEPTH];

    logic [IDX_W-1:0] word_idx;
    logic             accept;
    logic             out_of_range;
    logic             access_err;
    logic             mem_we;
    logic             misalign_err;
    logic [3:0]       byte_en;
    logic [31:0]      wdata_lanes;
    logic [31:0]      rdata_ext;
    logic [31:0]      rd_word;

    logic             rsp_valid_q;
    logic             rsp_err_q;
    logic [31:0]      rsp_rdata_q;

    assign word_idx     = bus.req_addr[IDX_W+1:2];
    // Any set bit above the word index puts the address at or beyond 4*DEPTH.
    assign out_of_range = |bus.req_addr[ADDR_W-1:IDX_W+2];
    assign accept       = bus.req_valid && (state == ST_IDLE);
    assign access_err   = out_of_range || (bus.req_size == SZ_RSVD) || misalign_err;
    assign mem_we       = accept && bus.req_we && !access_err;
    assign rd_word      = mem[word_idx];

    dmem_lane_align u_align (
        .size        (bus.req_size),
        .is_signed   (bus.req_signed),
        .addr_lo     (bus.req_addr[1:0]),
        .wdata       (bus.req_wdata),
        .rword       (rd_word),
        .byte_en     (byte_en),
        .wdata_lanes (wdata_lanes),
        .rdata_ext   (rdata_ext),
        .misalign_err(misalign_err)
    );

    // Sweep FSM: DEPTH clearing cycles after reset, then IDLE until the next reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + IDX_W'(1);
            if (clr_cnt == IDX_W'(DEPTH - 1)) begin
                state <= ST_IDLE;
            end
        end
    end

    // NOTE: the storage array has no reset term; it stays a plain RAM and the
    // sweep does the clearing, one word per cycle.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
                end
            end
        end
    end

    // Response is captured at the accepting edge from the pre-write contents,
    // so a load sees every store accepted on an earlier edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            rsp_valid_q <= accept;
            rsp_err_q   <= accept && access_err;
            rsp_rdata_q <= (accept && !bus.req_we && !access_err) ? rdata_ext : 32'h0;
        end
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.init_busy = (state == ST_CLEAR);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: self-checking bench for dmem_ctrl. A byte-array reference
// model computes every expected response; directed cases also compare
// against hand-derived constants, followed by randomized traffic.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dmem_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] model_mem [4*DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4*DEPTH; i++) model_mem[i] = 8'h00;
    endtask

    // Behavioural reference: byte-addressed little-endian memory.
    task automatic model_access(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic err);
        int nbytes;
        int base;
        logic [31:0] v;
        err = 1'b0;
        rd  = 32'h0;
        if (size == 2'b11) err = 1'b1;
        if (addr >= 32'(4*DEPTH)) err = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00)) err = 1'b1;
`endif
        if (!err) begin
            nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
            base   = int'(addr) & ~(nbytes - 1);
            if (we) begin
                for (int i = 0; i < nbytes; i++) model_mem[base+i] = wdata[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < nbytes; i++) v = v | (32'(model_mem[base+i]) << (8*i));
                if (sgn && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8*nbytes));
                rd = v;
            end
        end
    endtask

    // Called just after a falling edge; returns with the response checked at the next one.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic err);
        logic [31:0] exp_rd;
        logic        exp_err;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        check("req_ready", 32'(bus.req_ready), 32'd1);
        model_access(we, size, sgn, addr, wdata, exp_rd, exp_err);
        @(posedge clk);
        @(negedge clk);
        rd  = bus.rsp_rdata;
        err = bus.rsp_err;
        check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rsp_err_model", 32'(err), 32'(exp_err));
        check("rsp_rdata_model", rd, exp_rd);
    endtask

    task automatic directed(input string tag, input logic we, input logic [1:0] size,
                            input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        err;
        issue(we, size, sgn, addr, wdata, rd, err);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic idle_cycle();
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_no_rsp", 32'(bus.rsp_valid), 32'd0);
    endtask

    // A store is held on the bus through the sweep; it must never be accepted.
    task automatic hold_store_during_sweep();
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_size   = SZ_WORD;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h10;
        bus.req_wdata  = 32'hFFFF_FFFF;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
        check({tag, "_busy"}, 32'(bus.init_busy), 32'd1);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
        check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    endtask

    task automatic wait_init();
        int cycles = 0;
        bit saw_rsp = 1'b0;
        while (bus.init_busy && cycles < 1000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.rsp_valid) saw_rsp = 1'b1;
        end
        check("sweep_cycles", 32'(cycles), 32'd256);
        check("sweep_no_rsp", 32'(saw_rsp), 32'd0);
        check("ready_after_sweep", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic full_reset();
        hold_store_during_sweep();
        rst = 1'b1;
        #1;
        check_reset_values("reset");
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        wait_init();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        logic        we;
        logic        sgn;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          sel;

        full_reset();

        // Basic post-sweep content and lane behaviour.
        directed("lw_0x10_zero", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
        directed("sw_0x20", 1'b1, SZ_WORD, 1'b0, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0);
        directed("lw_0x20", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0);
        directed("lb_0x23", 1'b0, SZ_BYTE, 1'b1, 32'h23, 32'h0, 32'hFFFF_FFDE, 1'b0);
        directed("lbu_0x20", 1'b0, SZ_BYTE, 1'b0, 32'h20, 32'h0, 32'h0000_00EF, 1'b0);
        directed("lhu_0x22", 1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0, 32'h0000_DEAD, 1'b0);
        // Back-to-back: store then immediate read-after-write.
        directed("sh_0x22", 1'b1, SZ_HALF, 1'b0, 32'h22, 32'h0000_1234, 32'h0, 1'b0);
        directed("raw_lw_0x20", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h1234_BEEF, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        directed("lw_0x21_trap", 1'b0, SZ_WORD, 1'b0, 32'h21, 32'h0, 32'h0, 1'b1);
`else
        directed("lw_0x21_noalign", 1'b0, SZ_WORD, 1'b0, 32'h21, 32'h0, 32'h1234_BEEF, 1'b0);
`endif
        directed("lw_0x20_after_mis", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h1234_BEEF, 1'b0);
        directed("sw_oor", 1'b1, SZ_WORD, 1'b0, 32'h400, 32'hA5A5_A5A5, 32'h0, 1'b1);
        directed("lw_0x0_after_oor", 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        directed("ld_rsvd", 1'b0, SZ_RSVD, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1);
        directed("st_rsvd", 1'b1, SZ_RSVD, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1);
        directed("lw_0x20_after_rsvd", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h1234_BEEF, 1'b0);
        directed("lh_0x3fe_top", 1'b0, SZ_HALF, 1'b1, 32'h3FE, 32'h0, 32'h0, 1'b0);
        idle_cycle();

        // Reset in the middle of the clear sweep.
        hold_store_during_sweep();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("mid_sweep_rst");
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        wait_init();

        // Reset one cycle after a load is accepted.
        directed("sw_0x40", 1'b1, SZ_WORD, 1'b0, 32'h40, 32'hCAFE_F00D, 32'h0, 1'b0);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_size   = SZ_WORD;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h40;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("mid_load_rst");
        hold_store_during_sweep();
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        wait_init();
        directed("lw_0x40_cleared", 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle_cycle();
            end else begin
                we    = 1'($urandom_range(0, 1));
                sgn   = 1'($urandom_range(0, 1));
                size  = 2'($urandom_range(0, 3));
                sel   = int'($urandom_range(0, 9));
                wdata = $urandom();
                if (sel == 0)      addr = $urandom();
                else if (sel == 1) addr = 32'($urandom_range(0, 4*DEPTH - 1));
                else               addr = 32'($urandom_range(0, 63));
                issue(we, size, sgn, addr, wdata, rd, err);
            end
        end
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
